// File: rtl/ysyx_220053_shift_add_mul_if.sv
// Request/response bundle between operand issue and the iterative multiplier.
// The master is the issuing stage and the slave is the multiplier.
interface ysyx_220053_shift_add_mul_if #(
  parameter int unsigned WIDTH = 64
);
  logic             mul_valid;
  logic             mul_ready;
  logic             flush;
  logic             mulw;
  logic [1:0]       mul_signed;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;

  modport master (
    output mul_valid, flush, mulw, mul_signed, multiplicand, multiplier, out_ready,
    input  mul_ready, out_valid, result_hi, result_lo
  );

  modport slave (
    input  mul_valid, flush, mulw, mul_signed, multiplicand, multiplier, out_ready,
    output mul_ready, out_valid, result_hi, result_lo
  );
endinterface

// File: rtl/ysyx_220053_shift_add_mul.sv
// Radix-2 shift-add multiplier for RV64M MUL/MULH/MULHSU/MULHU/MULW.
// One multiplier bit per cycle, accumulated through a 2*WIDTH carry-lookahead adder.
module ysyx_220053_shift_add_mul #(
  parameter int unsigned WIDTH = 64
) (
  input logic                           clk,
  input logic                           rst_n,
  ysyx_220053_shift_add_mul_if.slave    mul_if
);
  localparam int unsigned W2   = 2 * WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam int unsigned NGrp = W2 / 4;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [CntW-1:0] LastW = CntW'(31);
  localparam logic [CntW-1:0] LastD = CntW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [W2-1:0]    a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             mulw_q, mulw_d;
  logic             bsign_q, bsign_d;

  logic             accept;
  logic             is_last;
  logic             do_sub;
  logic [W2-1:0]    mcand_ext;
  logic [WIDTH-1:0] mplier_ext;
  logic [W2-1:0]    add_x, add_y, add_sum;
  logic             add_cin;
  logic             unused_add_cout;

  assign accept  = (state_q == StIdle) && mul_if.mul_valid && !mul_if.flush;
  assign is_last = (cnt_q == (mulw_q ? LastW : LastD));
  // The top multiplier bit carries weight -2^(N-1) when signed, so it subtracts.
  assign do_sub  = is_last && bsign_q;

  always_comb begin
    mcand_ext  = {{WIDTH{1'b0}}, mul_if.multiplicand};
    mplier_ext = mul_if.multiplier;
    if (mul_if.mulw) begin
      mcand_ext  = {{(W2-32){mul_if.multiplicand[31]}}, mul_if.multiplicand[31:0]};
      mplier_ext = {{(WIDTH-32){1'b0}}, mul_if.multiplier[31:0]};
    end else if (mul_if.mul_signed[1]) begin
      mcand_ext  = {{WIDTH{mul_if.multiplicand[WIDTH-1]}}, mul_if.multiplicand};
    end
  end

  assign add_x   = acc_q;
  assign add_y   = b_q[0] ? (do_sub ? ~a_q : a_q) : '0;
  assign add_cin = b_q[0] & do_sub;

  for (genvar g = 0; g < NGrp; g++) begin : g_cla
    logic       cin_g;
    logic       cout;
    logic [3:0] p, gn, c_hi;
    if (g == 0) begin : g_first
      assign cin_g = add_cin;
    end else begin : g_rest
      assign cin_g = g_cla[g-1].cout;
    end
    assign p  = add_x[4*g +: 4] ^ add_y[4*g +: 4];
    assign gn = add_x[4*g +: 4] & add_y[4*g +: 4];
    assign c_hi[0] = gn[0] | (p[0] & cin_g);
    assign c_hi[1] = gn[1] | (p[1] & gn[0]) | (p[1] & p[0] & cin_g);
    assign c_hi[2] = gn[2] | (p[2] & gn[1]) | (p[2] & p[1] & gn[0])
                   | (p[2] & p[1] & p[0] & cin_g);
    assign c_hi[3] = gn[3] | (p[3] & gn[2]) | (p[3] & p[2] & gn[1])
                   | (p[3] & p[2] & p[1] & gn[0]) | (p[3] & p[2] & p[1] & p[0] & cin_g);
    assign cout = c_hi[3];
    assign add_sum[4*g +: 4] = p ^ {c_hi[2:0], cin_g};
  end

  // Carry out of bit 2W-1 is dropped: arithmetic is modulo 2^(2W).
  assign unused_add_cout = g_cla[NGrp-1].cout;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mulw_d  = mulw_q;
    bsign_d = bsign_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          a_d     = mcand_ext;
          b_d     = mplier_ext;
          acc_d   = '0;
          cnt_d   = '0;
          mulw_d  = mul_if.mulw;
          bsign_d = mul_if.mulw | mul_if.mul_signed[0];
          state_d = StBusy;
        end
      end
      StBusy: begin
        acc_d = add_sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CntW'(1);
        if (is_last) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (mul_if.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (mul_if.flush) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      mulw_q  <= 1'b0;
      bsign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mulw_q  <= mulw_d;
      bsign_q <= bsign_d;
    end
  end

  always_comb begin
    mul_if.mul_ready = (state_q == StIdle);
    mul_if.out_valid = (state_q == StDone);
    mul_if.result_hi = '0;
    mul_if.result_lo = '0;
    if (state_q == StDone) begin
      if (mulw_q) begin
        mul_if.result_lo = {{(WIDTH-32){acc_q[31]}}, acc_q[31:0]};
      end else begin
        mul_if.result_hi = acc_q[W2-1:WIDTH];
        mul_if.result_lo = acc_q[WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_ysyx_220053_shift_add_mul.sv
// Directed bench for the shift-add multiplier: products, latency, handshake,
// flush and asynchronous reset behaviour against hand-computed constants.
module tb_ysyx_220053_shift_add_mul;
  localparam int unsigned WIDTH = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ysyx_220053_shift_add_mul_if #(.WIDTH(WIDTH)) mif ();

  ysyx_220053_shift_add_mul #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .mul_if (mif.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h want 0x%016h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [1:0] s, input logic [63:0] a,
                       input logic [63:0] b);
    @(negedge clk);
    mif.mulw         = w;
    mif.mul_signed   = s;
    mif.multiplicand = a;
    mif.multiplier   = b;
    mif.mul_valid    = 1'b1;
    check_eq("ready_at_issue", mif.mul_ready, 1);
    @(posedge clk);
    #1;
    // Scramble operands while busy; the captured values must be used.
    mif.mul_valid    = 1'b0;
    mif.mulw         = ~w;
    mif.mul_signed   = ~s;
    mif.multiplicand = 64'hDEAD_BEEF_0BAD_F00D;
    mif.multiplier   = 64'h5A5A_A5A5_C3C3_3C3C;
  endtask

  // Counts edges from the accept edge (inclusive) until out_valid is seen.
  task automatic wait_done(input string tag, input int exp_lat);
    int lat = 1;
    while (!mif.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic handoff(input string tag);
    check_eq({tag, "_ready_in_done"}, mif.mul_ready, 0);
    mif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    mif.out_ready = 1'b0;
    check_eq({tag, "_valid_after"}, mif.out_valid, 0);
    check_eq({tag, "_ready_after"}, mif.mul_ready, 1);
  endtask

  task automatic do_op(input string tag, input logic w, input logic [1:0] s,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp_hi, input logic [63:0] exp_lo);
    issue(w, s, a, b);
    wait_done(tag, w ? 33 : 65);
    check_eq({tag, "_hi"}, mif.result_hi, exp_hi);
    check_eq({tag, "_lo"}, mif.result_lo, exp_lo);
    handoff(tag);
  endtask

  task automatic watch_idle(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (mif.out_valid) seen++;
    end
    check_eq({tag, "_no_valid"}, 64'(seen), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n            = 1'b0;
    mif.mul_valid    = 1'b0;
    mif.flush        = 1'b0;
    mif.mulw         = 1'b0;
    mif.mul_signed   = 2'b00;
    mif.multiplicand = '0;
    mif.multiplier   = '0;
    mif.out_ready    = 1'b0;
    #12;
    check_eq("rst_ready", mif.mul_ready, 1);
    check_eq("rst_valid", mif.out_valid, 0);
    check_eq("rst_hi", mif.result_hi, 0);
    check_eq("rst_lo", mif.result_lo, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("u3x5", 1'b0, 2'b00, 64'd3, 64'd5, 64'd0, 64'd15);
    do_op("mulhu_max", 1'b0, 2'b00, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1);
    do_op("s_m1xm1", 1'b0, 2'b11, '1, '1, 64'd0, 64'd1);
    do_op("s_minxm1", 1'b0, 2'b11, 64'h8000_0000_0000_0000, '1,
          64'd0, 64'h8000_0000_0000_0000);
    do_op("s_m3x7", 1'b0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7,
          '1, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op("su_m1x2", 1'b0, 2'b10, '1, 64'd2, '1, 64'hFFFF_FFFF_FFFF_FFFE);
    do_op("w_max_x2", 1'b1, 2'b00, 64'h7FFF_FFFF, 64'd2, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE);
    do_op("w_m1x3", 1'b1, 2'b00, 64'h1234_5678_FFFF_FFFF, 64'hABCD_EF00_0000_0003,
          64'd0, 64'hFFFF_FFFF_FFFF_FFFD);

    // Output holds while the consumer stalls.
    issue(1'b0, 2'b00, 64'd3, 64'd5);
    wait_done("stall", 65);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_eq("stall_valid", mif.out_valid, 1);
      check_eq("stall_hi", mif.result_hi, 0);
      check_eq("stall_lo", mif.result_lo, 15);
    end
    handoff("stall");

    // Flush in BUSY cycle 10 discards the operation.
    issue(1'b0, 2'b00, 64'd3, 64'd5);
    repeat (9) @(posedge clk);
    #1;
    mif.flush = 1'b1;
    @(posedge clk);
    #1;
    mif.flush = 1'b0;
    check_eq("flush_busy_ready", mif.mul_ready, 1);
    check_eq("flush_busy_valid", mif.out_valid, 0);
    watch_idle("flush_busy", 70);

    // Flush in IDLE blocks acceptance.
    @(negedge clk);
    mif.mul_valid = 1'b1;
    mif.flush     = 1'b1;
    @(posedge clk);
    #1;
    mif.mul_valid = 1'b0;
    mif.flush     = 1'b0;
    check_eq("flush_idle_ready", mif.mul_ready, 1);
    watch_idle("flush_idle", 70);

    // Flush together with out_ready in DONE.
    issue(1'b0, 2'b00, 64'd6, 64'd7);
    wait_done("flush_done", 65);
    check_eq("flush_done_lo", mif.result_lo, 42);
    mif.out_ready = 1'b1;
    mif.flush     = 1'b1;
    @(posedge clk);
    #1;
    mif.out_ready = 1'b0;
    mif.flush     = 1'b0;
    check_eq("flush_done_valid", mif.out_valid, 0);
    check_eq("flush_done_ready", mif.mul_ready, 1);

    // Asynchronous reset mid-BUSY.
    issue(1'b0, 2'b00, '1, '1);
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_ready", mif.mul_ready, 1);
    check_eq("arst_valid", mif.out_valid, 0);
    check_eq("arst_hi", mif.result_hi, 0);
    check_eq("arst_lo", mif.result_lo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_idle("arst", 70);
    do_op("post_rst", 1'b0, 2'b00, 64'd9, 64'd11, 64'd0, 64'd99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
